bram_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one single-port BRAM (1-cycle registered read) between
//  NUM_REQ requesters: frame send path, constant-header writer, checksum engine.

---
 rtl/bram_port_arbiter_if.sv | 37 +++
 rtl/bram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the single-port BRAM.
// Requester side: i_req/i_we/i_lock/i_addr/i_wdata in, o_gnt/o_rvalid/o_rdata out.
// Memory side: o_mem_* out, i_mem_rdata in. Signal names follow the arbiter's view.
interface bram_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ-1:0]        i_we;
  logic [NUM_REQ-1:0]        i_lock;
  logic [NUM_REQ*ADDR_W-1:0] i_addr;
  logic [NUM_REQ*DATA_W-1:0] i_wdata;
  logic [NUM_REQ-1:0]        o_gnt;
  logic [NUM_REQ-1:0]        o_rvalid;
  logic [DATA_W-1:0]         o_rdata;
  logic                      o_busy;
  logic                      o_mem_en;
  logic                      o_mem_we;
  logic [ADDR_W-1:0]         o_mem_addr;
  logic [DATA_W-1:0]         o_mem_wdata;
  logic [DATA_W-1:0]         i_mem_rdata;

  // Arbiter side.
  modport slave (
    input  i_req, i_we, i_lock, i_addr, i_wdata, i_mem_rdata,
    output o_gnt, o_rvalid, o_rdata, o_busy,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  // Requester / memory side.
  modport master (
    output i_req, i_we, i_lock, i_addr, i_wdata, i_mem_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_busy,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters exclusive turns on one single-port
// BRAM with a 1-cycle registered read. One access per two cycles (IDLE -> ISSUE).
// Optional burst lock: define MEMARB_BURST_LOCK_EN to let a requester holding i_lock
// keep the port across consecutive accesses.
module bram_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  bram_port_arbiter_if.slave   bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic                busy_q, busy_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [IDX_W-1:0]    last_winner_q, last_winner_d;
  logic                rd_pend_q, rd_pend_d;

  logic [IDX_W-1:0]    rr_winner;
  logic                rr_found;
  logic [IDX_W-1:0]    winner;
  int                  cand;

  // Round-robin search: first active request after last_winner, wrapping.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so the search reads the values just computed and no latch is inferred.
    rr_winner = last_winner_q;
    rr_found  = 1'b0;
    cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_winner_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!rr_found && bus.i_req[cand]) begin
        rr_found  = 1'b1;
        rr_winner = IDX_W'(cand);
      end
    end
  end

`ifdef MEMARB_BURST_LOCK_EN
  logic              lock_vld_q, lock_vld_d;
  logic [IDX_W-1:0]  lock_owner_q, lock_owner_d;
  logic              lock_hit;

  // Lock owner pre-empts round-robin while it keeps requesting.
  always_comb begin
    lock_hit = lock_vld_q && bus.i_req[lock_owner_q];
    winner   = lock_hit ? lock_owner_q : rr_winner;
  end
`else
  logic lock_unused;
  assign lock_unused = ^bus.i_lock;

  // Pure round-robin: i_lock has no effect.
  always_comb begin
    winner = rr_winner;
  end
`endif

  // Next-state and registered-output logic of the IDLE/ISSUE FSM.
  always_comb begin
    state_d       = state_q;
    gnt_d         = '0;
    rvalid_d      = '0;
    busy_d        = 1'b0;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    last_winner_d = last_winner_q;
    rd_pend_d     = rd_pend_q;
`ifdef MEMARB_BURST_LOCK_EN
    lock_vld_d    = lock_vld_q;
    lock_owner_d  = lock_owner_q;
    if (state_q == S_IDLE && lock_vld_q && !bus.i_req[lock_owner_q]) lock_vld_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|bus.i_req) begin
          mem_en_d      = 1'b1;
          mem_we_d      = bus.i_we[winner];
          mem_addr_d    = bus.i_addr[winner*ADDR_W +: ADDR_W];
          mem_wdata_d   = bus.i_wdata[winner*DATA_W +: DATA_W];
          gnt_d         = NUM_REQ'(1) << winner;
          busy_d        = 1'b1;
          last_winner_d = winner;
          rd_pend_d     = ~bus.i_we[winner];
          state_d       = S_ISSUE;
`ifdef MEMARB_BURST_LOCK_EN
          if (bus.i_lock[winner]) begin
            lock_vld_d   = 1'b1;
            lock_owner_d = winner;
          end else if (lock_vld_q && winner == lock_owner_q) begin
            lock_vld_d   = 1'b0;
          end
`endif
        end
      end
      S_ISSUE: begin
        rvalid_d  = rd_pend_q ? (NUM_REQ'(1) << last_winner_q) : '0;
        rd_pend_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: flops use non-blocking '<=' so every register samples pre-edge values;
    // the address/data registers are reset too because they drive the BRAM port.
    if (i_rst) begin
      state_q       <= S_IDLE;
      gnt_q         <= '0;
      rvalid_q      <= '0;
      busy_q        <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      last_winner_q <= IDX_W'(NUM_REQ - 1);
      rd_pend_q     <= 1'b0;
`ifdef MEMARB_BURST_LOCK_EN
      lock_vld_q    <= 1'b0;
      lock_owner_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rvalid_q      <= rvalid_d;
      busy_q        <= busy_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      last_winner_q <= last_winner_d;
      rd_pend_q     <= rd_pend_d;
`ifdef MEMARB_BURST_LOCK_EN
      lock_vld_q    <= lock_vld_d;
      lock_owner_q  <= lock_owner_d;
`endif
    end
  end

  assign bus.o_gnt       = gnt_q;
  assign bus.o_rvalid    = rvalid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_rdata     = bus.i_mem_rdata;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed testbench for bram_port_arbiter with a behavioural single-port BRAM
// (registered read). Expectations follow MEMARB_BURST_LOCK_EN when it is defined.
module tb_bram_port_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  bram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bram_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: write or registered read on the enabled edge; tb preload port.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.o_mem_en) begin
      if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
      else              bus.i_mem_rdata     <= mem[bus.o_mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [NUM_REQ-1:0] exp6 [5];
  int ng;
  int c0;

  initial begin
    rst         = 1'b1;
    pre_we      = 1'b1;
    pre_addr    = 10'h005;
    pre_data    = 8'h83;
    bus.i_req   = '0;
    bus.i_we    = '0;
    bus.i_lock  = '0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    tick();
    pre_we = 1'b0;
    tick();
    // Reset state
    check("rst_gnt",    bus.o_gnt,       0);
    check("rst_rvalid", bus.o_rvalid,    0);
    check("rst_busy",   bus.o_busy,      0);
    check("rst_en",     bus.o_mem_en,    0);
    check("rst_we",     bus.o_mem_we,    0);
    check("rst_addr",   bus.o_mem_addr,  0);
    check("rst_wdata",  bus.o_mem_wdata, 0);
    rst = 1'b0;
    tick();

    // Test 1: req0 reads 0x005 (preloaded 0x83)
    bus.i_addr[0*ADDR_W +: ADDR_W] = 10'h005;
    bus.i_req = 3'b001;
    tick();
    check("t1_gnt",  bus.o_gnt,      3'b001);
    check("t1_addr", bus.o_mem_addr, 10'h005);
    check("t1_en",   bus.o_mem_en,   1);
    check("t1_we",   bus.o_mem_we,   0);
    check("t1_busy", bus.o_busy,     1);
    bus.i_req = 3'b000;
    tick();
    check("t1_rvalid",    bus.o_rvalid,   3'b001);
    check("t1_rdata",     bus.o_rdata,    8'h83);
    check("t1_gnt_off",   bus.o_gnt,      0);
    check("t1_busy_off",  bus.o_busy,     0);
    tick();
    check("t1_idle_en",   bus.o_mem_en,   0);
    check("t1_idle_addr", bus.o_mem_addr, 10'h005);
    check("t1_rv_pulse",  bus.o_rvalid,   0);

    // Test 2: after reset, all three read together
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_req = 3'b111;
    tick();
    check("t2_gnt0", bus.o_gnt, 3'b001);
    bus.i_req[0] = 1'b0;
    tick();
    check("t2_rv0",  bus.o_rvalid, 3'b001);
    check("t2_gap0", bus.o_gnt,    0);
    tick();
    check("t2_gnt1", bus.o_gnt, 3'b010);
    bus.i_req[1] = 1'b0;
    tick();
    check("t2_rv1",  bus.o_rvalid, 3'b010);
    tick();
    check("t2_gnt2", bus.o_gnt, 3'b100);
    bus.i_req[2] = 1'b0;
    tick();
    check("t2_rv2",  bus.o_rvalid, 3'b100);

    // Test 3: req0 and req2 held for 8 accesses -> 0,2,0,2,...
    bus.i_req = 3'b101;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t3_gnt%0d", i), bus.o_gnt, (i % 2 == 0) ? 3'b001 : 3'b100);
      if (i == 7) bus.i_req = 3'b000;
      tick();
    end

    // Test 4: req1 writes 0xA5 @0x009, req2 reads it back
    bus.i_we[1] = 1'b1;
    bus.i_addr[1*ADDR_W +: ADDR_W]  = 10'h009;
    bus.i_wdata[1*DATA_W +: DATA_W] = 8'hA5;
    bus.i_req = 3'b010;
    tick();
    check("t4_wgnt",  bus.o_gnt,       3'b010);
    check("t4_wwe",   bus.o_mem_we,    1);
    check("t4_waddr", bus.o_mem_addr,  10'h009);
    check("t4_wdata", bus.o_mem_wdata, 8'hA5);
    bus.i_req   = 3'b000;
    bus.i_we[1] = 1'b0;
    tick();
    check("t4_wrv",   bus.o_rvalid, 0);
    bus.i_addr[2*ADDR_W +: ADDR_W] = 10'h009;
    bus.i_req = 3'b100;
    tick();
    check("t4_rgnt",  bus.o_gnt, 3'b100);
    bus.i_req = 3'b000;
    tick();
    check("t4_rrv",    bus.o_rvalid, 3'b100);
    check("t4_rrdata", bus.o_rdata,  8'hA5);

    // Test 5: reset during ISSUE of a read
    bus.i_req = 3'b001;
    tick();
    check("t5_gnt", bus.o_gnt, 3'b001);
    bus.i_req = 3'b000;
    rst = 1'b1;
    tick();
    check("t5_rvalid", bus.o_rvalid,   0);
    check("t5_gnt0",   bus.o_gnt,      0);
    check("t5_busy",   bus.o_busy,     0);
    check("t5_en",     bus.o_mem_en,   0);
    check("t5_addr",   bus.o_mem_addr, 0);
    rst = 1'b0;
    tick();
    check("t5_norv", bus.o_rvalid, 0);
    bus.i_req = 3'b011;
    tick();
    check("t5_first", bus.o_gnt, 3'b001);
    bus.i_req[0] = 1'b0;
    tick();
    tick();
    check("t5_second", bus.o_gnt, 3'b010);
    bus.i_req = 3'b000;
    tick();

    // Test 6: req0 locks for 4 accesses while req1 waits
`ifdef MEMARB_BURST_LOCK_EN
    ng = 5;
    exp6[0] = 3'b001; exp6[1] = 3'b001; exp6[2] = 3'b001; exp6[3] = 3'b001;
    exp6[4] = 3'b010;
`else
    ng = 4;
    exp6[0] = 3'b001; exp6[1] = 3'b010; exp6[2] = 3'b001; exp6[3] = 3'b010;
    exp6[4] = 3'b000;
`endif
    c0 = 0;
    bus.i_lock = 3'b001;
    bus.i_req  = 3'b011;
    for (int g = 0; g < ng; g++) begin
      tick();
      check($sformatf("t6_gnt%0d", g), bus.o_gnt, exp6[g]);
      if (exp6[g] == 3'b001) begin
        c0++;
        if (c0 == 4) begin
          bus.i_req[0]  = 1'b0;
          bus.i_lock[0] = 1'b0;
        end
      end
      tick();
    end
    bus.i_req  = 3'b000;
    bus.i_lock = 3'b000;
    tick();
    tick();
    check("t6_idle", bus.o_mem_en, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
